// File: rtl/marche_pkg.sv
// Shared MARCHE definitions: instruction width, NOP encoding, fetch FSM states.
package marche_pkg;

  localparam int unsigned INSTR_W      = 32;
  localparam int unsigned DEFAULT_PC_W = 21;
  localparam int unsigned BUF_CNT_W    = 2;

  localparam logic [0:INSTR_W-1] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_buf.sv
// Two-entry instruction FIFO of {instr, pc} with registered head outputs.
module fetch_buf
  import marche_pkg::*;
#(
  parameter int unsigned PC_W = DEFAULT_PC_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [0:INSTR_W-1]   push_instr,
  input  logic [0:PC_W-1]      push_pc,
  output logic [0:INSTR_W-1]   head_instr,
  output logic [0:PC_W-1]      head_pc,
  output logic                 head_valid,
  output logic [BUF_CNT_W-1:0] count
);

  logic [0:INSTR_W-1] tail_instr;
  logic [0:PC_W-1]    tail_pc;
  logic               pop_ok;

  assign pop_ok = pop && (count != BUF_CNT_W'(0));

  // Empty head always reads as a NOP at PC 0; flush wins over push.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_instr <= NOP_INSTR;
      head_pc    <= '0;
      head_valid <= 1'b0;
      tail_instr <= NOP_INSTR;
      tail_pc    <= '0;
      count      <= '0;
    end else begin
      case (count)
        BUF_CNT_W'(0): begin
          if (push) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
            head_valid <= 1'b1;
            count      <= BUF_CNT_W'(1);
          end
        end
        BUF_CNT_W'(1): begin
          if (push && pop_ok) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else if (push) begin
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
            count      <= BUF_CNT_W'(2);
          end else if (pop_ok) begin
            head_instr <= NOP_INSTR;
            head_pc    <= '0;
            head_valid <= 1'b0;
            count      <= BUF_CNT_W'(0);
          end
        end
        BUF_CNT_W'(2): begin
          if (pop_ok) begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            if (push) begin
              tail_instr <= push_instr;
              tail_pc    <= push_pc;
            end else begin
              tail_instr <= NOP_INSTR;
              tail_pc    <= '0;
              count      <= BUF_CNT_W'(1);
            end
          end
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// MARCHE instruction fetch: PC, imem req/ack handshake, redirect/drain FSM.
module instr_fetch
  import marche_pkg::*;
#(
  parameter int unsigned PC_W  = DEFAULT_PC_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [0:PC_W-1]    imem_addr,
  input  logic               imem_ack,
  input  logic [0:INSTR_W-1] imem_data,
  output logic [0:INSTR_W-1] instr,
  output logic [0:PC_W-1]    instr_pc,
  output logic               instr_valid,
  input  logic               dec_ready,
  input  logic               redirect,
  input  logic [0:PC_W-1]    redirect_pc
);

  fetch_state_e state, state_nxt;
  logic [0:PC_W-1] pc, pc_nxt;
  logic [0:PC_W-1] redir_pc, redir_pc_nxt;
  logic            push, pop, flush;
  logic            ack_c, pop_req_c;
  logic [BUF_CNT_W-1:0] count, occ_after;

  assign ack_c     = imem_req && imem_ack;
  assign pop_req_c = instr_valid && dec_ready;
  assign occ_after = count + BUF_CNT_W'(1) - BUF_CNT_W'(pop_req_c);

  // The request address is the PC register itself, so it holds until ack.
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FETCH;
      pc       <= '0;
      redir_pc <= '0;
      imem_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      redir_pc <= redir_pc_nxt;
      imem_req <= (state_nxt != HOLD);
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    redir_pc_nxt = redir_pc;
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (redirect) begin
      // An un-acked request must complete before the new PC can be issued.
      flush = 1'b1;
      if (imem_req && !imem_ack) begin
        redir_pc_nxt = redirect_pc;
        state_nxt    = DRAIN;
      end else begin
        pc_nxt    = redirect_pc;
        state_nxt = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          pop = pop_req_c;
          if (ack_c) begin
            push   = 1'b1;
            pc_nxt = pc + PC_W'(1);
            if (occ_after >= BUF_CNT_W'(DEPTH)) begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          pop = pop_req_c;
          if (pop_req_c) begin
            state_nxt = FETCH;
          end
        end
        DRAIN: begin
          if (ack_c) begin
            pc_nxt    = redir_pc;
            state_nxt = FETCH;
          end
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase
    end
  end

  fetch_buf #(
    .PC_W (PC_W)
  ) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_instr (imem_data),
    .push_pc    (pc),
    .head_instr (instr),
    .head_pc    (instr_pc),
    .head_valid (instr_valid),
    .count      (count)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: scoreboard of fetched {instr, pc} plus directed checks.
module tb_instr_fetch;

  localparam int unsigned PC_W = 21;

  logic             clk;
  logic             reset;
  logic             imem_req;
  logic [0:PC_W-1]  imem_addr;
  logic             imem_ack;
  logic [0:31]      imem_data;
  logic [0:31]      instr;
  logic [0:PC_W-1]  instr_pc;
  logic             instr_valid;
  logic             dec_ready;
  logic             redirect;
  logic [0:PC_W-1]  redirect_pc;

  int nerr    = 0;
  int nchecks = 0;

  int  ack_delay = 0;
  bit  ack_force = 1'b0;
  int  wcnt      = 0;
  int  npush     = 0;

  logic [52:0]     sb_q[$];
  logic [52:0]     sb_e;
  bit              stale    = 1'b0;
  bit              stab_chk = 1'b0;
  bit              was_rst  = 1'b0;
  bit              hs;
  logic [0:PC_W-1] exp_pc   = '0;
  logic [0:PC_W-1] pend_pc  = '0;
  logic [0:PC_W-1] prev_addr = '0;

  instr_fetch #(.PC_W(PC_W), .DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .dec_ready   (dec_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [20:0] a);
    return (32'(a) * 32'h0000_9E37) ^ 32'hA5C3_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory responder and scoreboard model, evaluated mid-cycle for the coming edge.
  always @(negedge clk) begin
    if (reset) wcnt = 0;
    if (ack_force || ack_delay == 0) imem_ack = 1'b1;
    else imem_ack = imem_req && (wcnt >= ack_delay);
    hs = imem_req && imem_ack;
    if (!reset) begin
      if (hs) wcnt = 0;
      else if (imem_req) wcnt++;
    end

    if (was_rst) begin
      check("rst_req",   64'(imem_req),    64'd0);
      check("rst_addr",  64'(imem_addr),   64'd0);
      check("rst_instr", 64'(instr),       64'd0);
      check("rst_pc",    64'(instr_pc),    64'd0);
      check("rst_valid", 64'(instr_valid), 64'd0);
    end else begin
      check("valid_vs_model", 64'(instr_valid), 64'(sb_q.size() != 0));
      if (!instr_valid) check("empty_nop", 64'({instr, instr_pc}), 64'd0);
      if (stab_chk) begin
        check("req_held",  64'(imem_req),  64'd1);
        check("addr_held", 64'(imem_addr), 64'(prev_addr));
      end
    end

    if (reset) begin
      sb_q.delete();
      stale  = 1'b0;
      exp_pc = '0;
    end else if (redirect) begin
      sb_q.delete();
      if (imem_req && !imem_ack) begin
        stale   = 1'b1;
        pend_pc = redirect_pc;
      end else begin
        stale  = 1'b0;
        exp_pc = redirect_pc;
      end
    end else begin
      if (instr_valid && dec_ready && sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("pop_entry", 64'({instr, instr_pc}), 64'(sb_e));
      end
      if (hs) begin
        if (stale) begin
          stale  = 1'b0;
          exp_pc = pend_pc;
        end else begin
          check("ack_addr", 64'(imem_addr), 64'(exp_pc));
          sb_q.push_back({mem_word(imem_addr), imem_addr});
          exp_pc = exp_pc + PC_W'(1);
          npush++;
        end
      end
    end

    stab_chk  = imem_req && !imem_ack && !reset;
    prev_addr = imem_addr;
    was_rst   = reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_req_addr(input logic [0:PC_W-1] a, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (imem_req && imem_addr == a) found = 1'b1;
      else tick(1);
    end
    check("wait_req_addr", 64'(found), 64'd1);
  endtask

  int p0;

  initial begin
    reset       = 1'b1;
    dec_ready   = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    tick(3);
    check("reset_req",   64'(imem_req),    64'd0);
    check("reset_valid", 64'(instr_valid), 64'd0);

    // Zero-wait streaming: one instruction per cycle, addresses 0,1,2,3.
    reset = 1'b0;
    tick(1);
    check("first_req", 64'(imem_req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("stream_addr", 64'(imem_addr), 64'(i));
      tick(1);
      check("stream_valid", 64'(instr_valid), 64'd1);
      check("stream_pc",    64'(instr_pc),    64'(i));
      check("stream_instr", 64'(instr),       64'(mem_word(21'(i))));
    end

    // Backpressure: buffer fills to two, request throttles, resumes after one pop.
    dec_ready = 1'b0;
    do_reset();
    tick(1);
    check("bp_req_c1", 64'(imem_req), 64'd1);
    tick(1);
    check("bp_req_c2", 64'(imem_req), 64'd1);
    tick(1);
    check("bp_req_c3", 64'(imem_req), 64'd0);
    tick(2);
    check("bp_hold_req",  64'(imem_req),  64'd0);
    check("bp_hold_addr", 64'(imem_addr), 64'd2);
    check("bp_head_pc",   64'(instr_pc),  64'd0);
    dec_ready = 1'b1;
    tick(1);
    check("bp_pop1_pc",  64'(instr_pc),  64'd1);
    check("bp_rereq",    64'(imem_req),  64'd1);
    check("bp_rereq_ad", 64'(imem_addr), 64'd2);
    tick(1);
    check("bp_pop2_pc",  64'(instr_pc),  64'd2);

    // Slow memory: 3 wait cycles per request.
    ack_delay = 3;
    do_reset();
    p0 = npush;
    tick(40);
    check("slow_pushes_ge9", 64'(npush - p0 >= 9), 64'd1);
    check("slow_pushes_le10", 64'(npush - p0 <= 10), 64'd1);

    // Redirect while request to 5 is waiting; its ack comes 2 cycles later.
    ack_delay = 2;
    do_reset();
    wait_req_addr(21'd5, 100);
    redirect    = 1'b1;
    redirect_pc = 21'h00100;
    tick(1);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("drain_addr",  64'(imem_addr),   64'd5);
      check("drain_req",   64'(imem_req),    64'd1);
      check("drain_valid", 64'(instr_valid), 64'd0);
      tick(1);
    end
    check("post_drain_addr", 64'(imem_addr), 64'h100);
    for (int i = 0; i < 3; i++) begin
      check("post_drain_valid", 64'(instr_valid), 64'd0);
      tick(1);
    end
    check("redir_valid", 64'(instr_valid), 64'd1);
    check("redir_pc",    64'(instr_pc),    64'h100);

    // Redirect coinciding with ack and pop, landing on the top PC to check wrap.
    ack_delay = 0;
    do_reset();
    tick(4);
    check("pre_redir_valid", 64'(instr_valid), 64'd1);
    redirect    = 1'b1;
    redirect_pc = 21'h1F_FFFF;
    tick(1);
    redirect = 1'b0;
    check("imm_addr",  64'(imem_addr),   64'h1F_FFFF);
    check("imm_valid", 64'(instr_valid), 64'd0);
    tick(1);
    check("wrap_addr",  64'(imem_addr), 64'd0);
    check("wrap_pc",    64'(instr_pc),  64'h1F_FFFF);
    check("wrap_instr", 64'(instr),     64'(mem_word(21'h1F_FFFF)));
    tick(1);
    check("wrap_next_pc", 64'(instr_pc), 64'd0);

    // Reset while draining, with ack arriving during reset.
    ack_delay = 4;
    do_reset();
    wait_req_addr(21'd2, 100);
    redirect    = 1'b1;
    redirect_pc = 21'h00055;
    tick(1);
    redirect  = 1'b0;
    reset     = 1'b1;
    ack_force = 1'b1;
    tick(2);
    check("mid_rst_req",   64'(imem_req),    64'd0);
    check("mid_rst_addr",  64'(imem_addr),   64'd0);
    check("mid_rst_valid", 64'(instr_valid), 64'd0);
    reset     = 1'b0;
    ack_force = 1'b0;
    check("after_rst_req", 64'(imem_req), 64'd0);
    tick(1);
    check("post_rst_req",  64'(imem_req),  64'd1);
    check("post_rst_addr", 64'(imem_addr), 64'd0);
    tick(8);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
